// File: rtl/sw_cond_pkg.sv
// Shared channel enumeration and default timing for the turn/hazard switch conditioner.
package sw_cond_pkg;

    typedef enum logic [1:0] {
        CH_LT  = 2'd0,
        CH_RT  = 2'd1,
        CH_HAZ = 2'd2
    } ch_e;

    localparam int NUM_CH              = 3;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int SYNC_STAGES_DEF     = 2;

    // Only the hazard channel's accepted rising edge drives the toggle latch.
    function automatic logic haz_toggle(input logic [NUM_CH-1:0] rise);
        return rise[CH_HAZ];
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: synchroniser chain, stability counter and accepted level d,
// plus a pulse on the edge where d is about to rise.
module switch_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic d_o,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   d_q, d_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            d_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            d_q    <= d_d;
            cnt_q  <= cnt_d;
        end
    end

    // Any cycle where s matches d restarts the count, so glitches never accumulate.
    always_comb begin
        d_d   = d_q;
        cnt_d = '0;
        if (s != d_q) begin
            if (cnt_q == CNT_LAST) begin
                d_d = s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign d_o    = d_q;
    assign rise_o = d_d & ~d_q;

endmodule

// File: rtl/turn_switch_conditioner.sv
// Cleans raw stalk and hazard switches into mutually exclusive lt/rt/haz levels
// for tailLight; the hazard button acts as a press-to-toggle latch.
module turn_switch_conditioner
    import sw_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic lt_raw,
    input  logic rt_raw,
    input  logic haz_raw,
    output logic lt,
    output logic rt,
    output logic haz,
    output logic fault
);

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] lvl;
    logic [NUM_CH-1:0] rise;
    logic              haz_latch_q, haz_latch_d;

    assign raw_vec = {haz_raw, rt_raw, lt_raw};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        switch_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (raw_vec[i]),
            .d_o    (lvl[i]),
            .rise_o (rise[i])
        );
    end

    always_comb begin
        haz_latch_d = haz_latch_q;
        if (haz_toggle(rise)) begin
            haz_latch_d = ~haz_latch_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            haz_latch_q <= 1'b0;
        end else begin
            haz_latch_q <= haz_latch_d;
        end
    end

    // Hazard overrides both turns; conflicting stalk levels cancel each other.
    assign haz   = haz_latch_q;
    assign fault = lvl[CH_LT] & lvl[CH_RT];
    assign lt    = lvl[CH_LT] & ~lvl[CH_RT] & ~haz_latch_q;
    assign rt    = lvl[CH_RT] & ~lvl[CH_LT] & ~haz_latch_q;

endmodule

// File: tb/tb_turn_switch_conditioner.sv
// Scoreboard bench: stimulus queues expected output levels per clock edge,
// a negedge monitor pops and compares them against the DUT.
module tb_turn_switch_conditioner;

    logic clk;
    logic rst;
    logic lt_raw, rt_raw, haz_raw;
    logic lt, rt, haz, fault;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;

    typedef struct {
        int    cyc;
        logic  lt;
        logic  rt;
        logic  haz;
        logic  fault;
        string name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    turn_switch_conditioner dut (
        .clk     (clk),
        .rst     (rst),
        .lt_raw  (lt_raw),
        .rt_raw  (rt_raw),
        .haz_raw (haz_raw),
        .lt      (lt),
        .rt      (rt),
        .haz     (haz),
        .fault   (fault)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string nm, input logic el, input logic er,
                         input logic eh, input logic ef);
        n_tests++;
        if ({lt, rt, haz, fault} !== {el, er, eh, ef}) begin
            n_fail++;
            $display("FAIL %s @edge %0d: lt/rt/haz/fault got %b%b%b%b expected %b%b%b%b",
                     nm, edge_cnt, lt, rt, haz, fault, el, er, eh, ef);
        end
    endtask

    // Monitor: compare every expectation whose edge has been reached.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
            mon_e = sb_q.pop_front();
            check(mon_e.name, mon_e.lt, mon_e.rt, mon_e.haz, mon_e.fault);
        end
    end

    task automatic expect_at(input int m, input logic el, input logic er,
                             input logic eh, input logic ef, input string nm);
        exp_t e;
        e.cyc   = edge_cnt + m;
        e.lt    = el;
        e.rt    = er;
        e.haz   = eh;
        e.fault = ef;
        e.name  = nm;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        lt_raw  = 1'b1;
        rt_raw  = 1'b1;
        haz_raw = 1'b1;
        #3;
        check("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check("reset_held", 1'b0, 1'b0, 1'b0, 1'b0);

        rst = 1'b1; lt_raw = 1'b0; rt_raw = 1'b0; haz_raw = 1'b0;
        expect_at(1, 0, 0, 0, 0, "post_reset_e1");
        expect_at(8, 0, 0, 0, 0, "post_reset_e8");
        step(10);

        lt_raw = 1'b1;
        expect_at(5, 0, 0, 0, 0, "lt_rise_e5");
        expect_at(6, 1, 0, 0, 0, "lt_rise_e6");
        step(8);
        lt_raw = 1'b0;
        expect_at(5, 1, 0, 0, 0, "lt_fall_e5");
        expect_at(6, 0, 0, 0, 0, "lt_fall_e6");
        step(8);

        lt_raw = 1'b1;
        step(3);
        lt_raw = 1'b0;
        for (int k = 2; k <= 26; k += 4) expect_at(k, 0, 0, 0, 0, "chatter");
        for (int i = 0; i < 20; i++) begin
            step(1);
            lt_raw = ~lt_raw;
        end
        lt_raw = 1'b0;
        step(8);

        lt_raw = 1'b1;
        expect_at(6, 1, 0, 0, 0, "lt_for_haz");
        step(8);
        haz_raw = 1'b1;
        expect_at(5, 1, 0, 0, 0, "haz1_e5");
        expect_at(6, 0, 0, 1, 0, "haz1_e6");
        step(8);
        haz_raw = 1'b0;
        expect_at(5, 0, 0, 1, 0, "haz1_rel_e5");
        expect_at(7, 0, 0, 1, 0, "haz1_rel_e7");
        step(8);
        haz_raw = 1'b1;
        expect_at(5, 0, 0, 1, 0, "haz2_e5");
        expect_at(6, 1, 0, 0, 0, "haz2_e6");
        step(8);
        haz_raw = 1'b0;
        expect_at(7, 1, 0, 0, 0, "haz2_rel");
        step(8);

        rt_raw = 1'b1;
        expect_at(5, 1, 0, 0, 0, "fault_e5");
        expect_at(6, 0, 0, 0, 1, "fault_e6");
        step(8);
        rt_raw = 1'b0;
        expect_at(5, 0, 0, 0, 1, "unfault_e5");
        expect_at(6, 1, 0, 0, 0, "unfault_e6");
        step(8);
        lt_raw = 1'b0;
        expect_at(6, 0, 0, 0, 0, "lt_off");
        step(8);
        rt_raw = 1'b1;
        expect_at(5, 0, 0, 0, 0, "rt_rise_e5");
        expect_at(6, 0, 1, 0, 0, "rt_rise_e6");
        step(8);
        rt_raw = 1'b0;
        expect_at(6, 0, 0, 0, 0, "rt_fall_e6");
        step(8);

        haz_raw = 1'b1;
        expect_at(6, 0, 0, 1, 0, "haz3_on");
        step(8);
        #5 rst = 1'b0;
        #1 check("reset_mid_async", 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        rst = 1'b1;
        expect_at(5, 0, 0, 0, 0, "held_press_e5");
        expect_at(6, 0, 0, 1, 0, "held_press_e6");
        step(8);
        haz_raw = 1'b0;
        step(8);

        for (int i = 0; i < 50 && sb_q.size() > 0; i++) step(1);
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation for edge %0d never checked", mon_e.name, mon_e.cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
